// File: rtl/llc_mem_responder_pkg.sv
// Shared types and constants for the LLC memory channel: line/address widths,
// request/response payloads, responder state encoding and the fill-pattern helper.
package llc_mem_responder_pkg;

    localparam int BITS_PER_WORD  = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int BITS_PER_LINE  = BITS_PER_WORD * WORDS_PER_LINE;
    localparam int LINE_ADDR_BITS = 28;
    localparam int HSIZE_BITS     = 3;
    localparam int HPROT_BITS     = 2;
    localparam int CNT_BITS       = 16;

    typedef logic [BITS_PER_LINE-1:0]  line_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

    typedef struct packed {
        logic                  hwrite;
        logic [HSIZE_BITS-1:0] hsize;
        logic [HPROT_BITS-1:0] hprot;
        line_addr_t            addr;
        line_t                 line;
    } llc_mem_req_t;

    typedef struct packed {
        line_t line;
    } llc_mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RSP     = 2'd3
    } llc_mem_resp_state_t;

    // Never-written lines read back as the line address repeated in every word.
    function automatic line_t fill_line(input line_addr_t addr);
        line_t l;
        l = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            l[w*BITS_PER_WORD +: BITS_PER_WORD] = {{(BITS_PER_WORD-LINE_ADDR_BITS){1'b0}}, addr};
        end
        return l;
    endfunction

endpackage

// File: rtl/llc_mem_responder_array.sv
// Backing store for the memory responder: 2**IDX_BITS lines with a per-line valid
// bit (cleared by reset), one write port and one registered read port.
module llc_mem_responder_array
    import llc_mem_responder_pkg::*;
#(
    parameter int IDX_BITS = 8
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [IDX_BITS-1:0] i_widx,
    input  line_t               i_wline,
    input  logic                i_re,
    input  logic [IDX_BITS-1:0] i_ridx,
    output line_t               o_rline,
    output logic                o_rvalid
);

    localparam int NLINES = 1 << IDX_BITS;

    line_t             r_mem [NLINES];
    logic [NLINES-1:0] r_valid;

    // Line data has no reset so it can map onto block RAM; validity lives separately.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wline;
        end
    end

    // Per-line valid bits, cleared asynchronously so stale data is never returned after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    // Registered read port, held until the next read so the top can sample it late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rline  <= '0;
            o_rvalid <= 1'b0;
        end else if (i_re) begin
            o_rline  <= r_mem[i_ridx];
            o_rvalid <= r_valid[i_ridx];
        end
    end

endmodule

// File: rtl/llc_mem_responder.sv
// Memory-side responder behind the LLC: serves one line read or write-back at a
// time with fixed latencies, returning stored data or an address fill pattern.
module llc_mem_responder
    import llc_mem_responder_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int RD_LAT   = 4,
    parameter int WR_LAT   = 2
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                llc_mem_req_valid,
    output logic                llc_mem_req_ready,
    input  llc_mem_req_t        llc_mem_req_i,
    output logic                llc_mem_rsp_valid,
    input  logic                llc_mem_rsp_ready,
    output llc_mem_rsp_t        llc_mem_rsp_o,
    output logic [CNT_BITS-1:0] rd_cnt,
    output logic [CNT_BITS-1:0] wr_cnt
);

    localparam logic [3:0]          RD_LAT_M1 = 4'(RD_LAT - 1);
    localparam logic [3:0]          WR_LAT_M1 = 4'(WR_LAT - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = 16'hFFFF;

    llc_mem_resp_state_t r_state;
    logic [3:0]          r_lat_cnt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    line_t               r_rsp_line;
    line_addr_t          r_rd_addr;
    logic [CNT_BITS-1:0] r_rd_cnt;
    logic [CNT_BITS-1:0] r_wr_cnt;

    logic                w_accept;
    logic                w_wr_accept;
    logic                w_rd_accept;
    logic [IDX_BITS-1:0] w_idx;
    line_t               w_arr_rline;
    logic                w_arr_rvalid;
    line_t               w_rsp_line;
    logic                w_unused_req;

    assign w_accept     = llc_mem_req_valid & r_req_ready;
    assign w_wr_accept  = w_accept & llc_mem_req_i.hwrite;
    assign w_rd_accept  = w_accept & ~llc_mem_req_i.hwrite;
    assign w_idx        = llc_mem_req_i.addr[IDX_BITS-1:0];
    // Only full-line transfers exist, so size and protection carry no meaning here.
    assign w_unused_req = ^{llc_mem_req_i.hsize, llc_mem_req_i.hprot};

    llc_mem_responder_array #(
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wr_accept),
        .i_widx   (w_idx),
        .i_wline  (llc_mem_req_i.line),
        .i_re     (w_rd_accept),
        .i_ridx   (w_idx),
        .o_rline  (w_arr_rline),
        .o_rvalid (w_arr_rvalid)
    );

    // Response line: stored data when the line was written, address fill pattern otherwise.
    always_comb begin
        w_rsp_line = '0;
        if (w_arr_rvalid) begin
            w_rsp_line = w_arr_rline;
        end else begin
            w_rsp_line = fill_line(r_rd_addr);
        end
    end

    // Control FSM with latency counter, registered handshake outputs and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lat_cnt   <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_line  <= '0;
            r_rd_addr   <= '0;
            r_rd_cnt    <= 16'd0;
            r_wr_cnt    <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (llc_mem_req_i.hwrite) begin
                            r_state   <= WR_WAIT;
                            r_lat_cnt <= WR_LAT_M1;
                            if (r_wr_cnt != CNT_MAX) begin
                                r_wr_cnt <= r_wr_cnt + 16'd1;
                            end
                        end else begin
                            r_state   <= RD_WAIT;
                            r_lat_cnt <= RD_LAT_M1;
                            r_rd_addr <= llc_mem_req_i.addr;
                            if (r_rd_cnt != CNT_MAX) begin
                                r_rd_cnt <= r_rd_cnt + 16'd1;
                            end
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state     <= RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_line  <= w_rsp_line;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                RSP: begin
                    if (llc_mem_rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_lat_cnt   <= 4'd0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign llc_mem_req_ready  = r_req_ready;
    assign llc_mem_rsp_valid  = r_rsp_valid;
    assign llc_mem_rsp_o.line = r_rsp_line;
    assign rd_cnt             = r_rd_cnt;
    assign wr_cnt             = r_wr_cnt;

endmodule

// File: tb/tb_llc_mem_responder.sv
// Self-checking bench for llc_mem_responder: directed scenarios plus randomized
// traffic against a line-array reference model.
module tb_llc_mem_responder;
    import llc_mem_responder_pkg::*;

    localparam int IDX_BITS = 8;
    localparam int RD_LAT   = 4;
    localparam int WR_LAT   = 2;
    localparam int NLINES   = 1 << IDX_BITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    llc_mem_req_t req;
    logic         rsp_valid;
    logic         rsp_ready;
    llc_mem_rsp_t rsp;
    logic [15:0]  rd_cnt;
    logic [15:0]  wr_cnt;

    llc_mem_responder #(
        .IDX_BITS (IDX_BITS),
        .RD_LAT   (RD_LAT),
        .WR_LAT   (WR_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .llc_mem_req_valid (req_valid),
        .llc_mem_req_ready (req_ready),
        .llc_mem_req_i     (req),
        .llc_mem_rsp_valid (rsp_valid),
        .llc_mem_rsp_ready (rsp_ready),
        .llc_mem_rsp_o     (rsp),
        .rd_cnt            (rd_cnt),
        .wr_cnt            (wr_cnt)
    );

    always #5 clk = ~clk;

    line_t       m_data [NLINES];
    bit          m_vld  [NLINES];
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic line_t model_read(input line_addr_t a);
        int    idx;
        line_t f;
        idx = int'(a) % NLINES;
        if (m_vld[idx]) return m_data[idx];
        for (int w = 0; w < WORDS_PER_LINE; w++) f[w*32 +: 32] = 32'(a);
        return f;
    endfunction

    function automatic line_t rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLINES; i++) m_vld[i] = 1'b0;
        exp_rd = 16'd0;
        exp_wr = 16'd0;
    endtask

    // Waits for ready, presents one request for exactly the accepting edge, returns in the following cycle.
    task automatic send_req(input logic wr, input line_addr_t a, input line_t l);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: req_ready=%b required 1 (waited %0d cycles)", req_ready, n);
        end
        req.hwrite = wr;
        req.hsize  = 3'($urandom);
        req.hprot  = 2'($urandom);
        req.addr   = a;
        req.line   = l;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        if (wr) begin
            m_data[int'(a) % NLINES] = l;
            m_vld[int'(a) % NLINES]  = 1'b1;
            if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
        end else begin
            if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
        end
    endtask

    task automatic do_write(input line_addr_t a, input line_t l);
        send_req(1'b1, a, l);
        for (int k = 0; k <= WR_LAT; k++) begin
            n_checks++;
            if (req_ready !== 1'(k >= WR_LAT) || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL write_busy k=%0d: req_ready=%b rsp_valid=%b required %b/0",
                         k, req_ready, rsp_valid, 1'(k >= WR_LAT));
            end
            if (k < WR_LAT) @(negedge clk);
        end
        n_checks++;
        if (wr_cnt !== exp_wr) begin
            n_fail++;
            $display("FAIL wr_cnt: got %h required %h", wr_cnt, exp_wr);
        end
    endtask

    task automatic do_read(input line_addr_t a, input int hold);
        line_t exp;
        int    lat    = 0;
        bit    stable = 1'b1;
        exp = model_read(a);
        send_req(1'b0, a, '0);
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != RD_LAT) begin
            n_fail++;
            $display("FAIL read_latency addr=%h: got %0d required %0d", a, lat, RD_LAT);
        end
        n_checks++;
        if (rsp.line !== exp || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data addr=%h: got %h ready=%b required %h ready=0", a, rsp.line, req_ready, exp);
        end
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp.line !== exp || req_ready !== 1'b0) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL read_hold addr=%h: valid=%b line=%h ready=%b required 1/%h/0", a, rsp_valid, rsp.line, req_ready, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_handshake: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
        end
        n_checks++;
        if (rd_cnt !== exp_rd) begin
            n_fail++;
            $display("FAIL rd_cnt: got %h required %h", rd_cnt, exp_rd);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp.line !== '0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rsp_valid=%b line=%h rd=%h wr=%h required 1/0/0/0/0",
                     req_ready, rsp_valid, rsp.line, rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_fill_read();
        do_read(28'h0000123, 0);
        n_checks++;
        if (rsp.line !== {4{32'h00000123}}) begin
            n_fail++;
            $display("FAIL fill_pattern: got %h required %h", rsp.line, {4{32'h00000123}});
        end
    endtask

    task automatic test_write_read();
        line_t l;
        l = rand_line();
        do_write(28'h0000040, l);
        do_read(28'h0000040, 0);
        n_checks++;
        if (rsp.line !== l) begin
            n_fail++;
            $display("FAIL write_read: got %h required %h", rsp.line, l);
        end
    endtask

    task automatic test_backpressure();
        do_read(28'h0ABCDEF, 10);
        do_read(28'h0000040, 3);
    endtask

    task automatic test_alias();
        line_t l;
        l = rand_line();
        do_write(28'h0000105, l);
        do_read(28'h0000005, 1);
        n_checks++;
        if (rsp.line !== l) begin
            n_fail++;
            $display("FAIL alias: got %h required %h", rsp.line, l);
        end
        do_read(28'h7654305, 0);
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        do_write(28'h0000077, rand_line());
        send_req(1'b0, 28'h0000077, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_wait: rsp_valid=%b required 0", rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_quiet: quiet=%b rd=%h wr=%h required 1/0/0", quiet, rd_cnt, wr_cnt);
        end
        do_read(28'h0000077, 0);
        send_req(1'b0, 28'h0000040, '0);
        repeat (RD_LAT) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_rsp: rsp_valid=%b required 1", rsp_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_async: rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_read(28'h0000040, 0);
    endtask

    task automatic test_saturation();
        force dut.r_rd_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_rd_cnt;
        exp_rd = 16'hFFFE;
        for (int i = 0; i < 3; i++) do_read(line_addr_t'($urandom), 0);
        n_checks++;
        if (rd_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL rd_saturate: got %h required ffff", rd_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            line_addr_t a;
            a = line_addr_t'(($urandom << 8) | $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) do_write(a, rand_line());
            else do_read(a, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req       = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill_read();
        test_write_read();
        test_backpressure();
        test_alias();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
